ahb_mtx_in_stage: RTL and testbench

- Bus-matrix input stage: the master-facing end of the request/grant handshake whose other end is each output-port arbiter.
- Accepts an AHB address phase from one master. If no output stage takes it that cycle, holds it in a register and stalls the master with HREADYOUTS=0.
- Presents the live or held transfer, plus a request flag, to the decoder and output arbiters.
- Routes the output-side data-phase response back to the master.

---
 rtl/ahb_mtx_pkg.sv | 32 +++
 rtl/ahb_mtx_addr_hold.sv | 60 ++++++
 rtl/ahb_mtx_in_stage.sv | 94 +++++++++
 tb/tb_ahb_mtx_in_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_mtx_pkg.sv
// Shared AHB bus-matrix types: HTRANS/HRESP encodings, address-phase bundle and
// the input-stage hold state.
package ahb_mtx_pkg;

    // Struct fields are sized for the widest supported bus; modules cast to their width.
    localparam int unsigned ADDR_W_MAX = 64;
    localparam int unsigned PROT_W_MAX = 8;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef struct packed {
        logic [ADDR_W_MAX-1:0] addr;
        logic [1:0]            trans;
        logic                  write;
        logic [2:0]            size;
        logic [2:0]            burst;
        logic [PROT_W_MAX-1:0] prot;
        logic                  lock;
    } addr_phase_t;

    typedef enum logic {
        StIdle = 1'b0,
        StPend = 1'b1
    } pend_state_t;

endpackage

// File: rtl/ahb_mtx_addr_hold.sv
// Held address-phase register bank with pend flag and live/held select.
// Captures a new transfer that no output stage accepted and holds it until released.
module ahb_mtx_addr_hold
    import ahb_mtx_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_new_trans,
    input  logic        i_release,
    input  logic        i_cancel,
    input  addr_phase_t i_live,
    output addr_phase_t o_sel,
    output logic        o_pend
);

    pend_state_t r_state;
    pend_state_t w_state_d;
    addr_phase_t r_held;
    logic        w_capture;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_held <= '0;
        end else if (w_capture) begin
            r_held <= i_live;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_capture = 1'b0;
        case (r_state)
            StIdle: begin
                // A transfer granted and accepted in its own cycle passes straight through.
                if (i_new_trans && !i_release) begin
                    w_state_d = StPend;
                    w_capture = 1'b1;
                end
            end
            StPend: begin
                if (i_release || i_cancel) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign o_pend = (r_state == StPend);
    assign o_sel  = o_pend ? r_held : i_live;

endmodule

// File: rtl/ahb_mtx_in_stage.sv
// AHB bus-matrix input stage: holds an unaccepted address phase and stalls the master.
// Optional macro AHB_MTX_IN_ERR_CANCEL_EN: first-cycle ERROR drops a held transfer.
module ahb_mtx_in_stage
    import ahb_mtx_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned PROT_WIDTH = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [PROT_WIDTH-1:0] HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    output logic                  HREADYOUTS,
    output logic                  HRESPS,
    input  logic                  grant_in,
    input  logic                  hready_m,
    input  logic                  hresp_m,
    input  logic                  data_sel,
    output logic                  req_out,
    output logic [ADDR_WIDTH-1:0] ADDR_M,
    output logic [1:0]            TRANS_M,
    output logic                  WRITE_M,
    output logic [2:0]            SIZE_M,
    output logic [2:0]            BURST_M,
    output logic [PROT_WIDTH-1:0] PROT_M,
    output logic                  LOCK_M,
    output logic                  pend
);

    addr_phase_t w_live;
    addr_phase_t w_sel;
    logic        w_new_trans;
    logic        w_release;
    logic        w_cancel;
    logic        w_pend;

    assign w_live.addr  = ADDR_W_MAX'(HADDRS);
    assign w_live.trans = HTRANSS;
    assign w_live.write = HWRITES;
    assign w_live.size  = HSIZES;
    assign w_live.burst = HBURSTS;
    assign w_live.prot  = PROT_W_MAX'(HPROTS);
    assign w_live.lock  = HMASTLOCKS;

    assign w_new_trans = HSELS & HREADYS & (HTRANSS != TRANS_IDLE);
    assign w_release   = grant_in & hready_m;

`ifdef AHB_MTX_IN_ERR_CANCEL_EN
    assign w_cancel = data_sel & (hresp_m == RESP_ERROR) & ~hready_m;
`else
    assign w_cancel = 1'b0;
`endif

    ahb_mtx_addr_hold u_addr_hold (
        .i_clk       (HCLK),
        .i_rst_n     (HRESETn),
        .i_new_trans (w_new_trans),
        .i_release   (w_release),
        .i_cancel    (w_cancel),
        .i_live      (w_live),
        .o_sel       (w_sel),
        .o_pend      (w_pend)
    );

    assign pend    = w_pend;
    assign ADDR_M  = ADDR_WIDTH'(w_sel.addr);
    assign TRANS_M = w_sel.trans;
    assign WRITE_M = w_sel.write;
    assign SIZE_M  = w_sel.size;
    assign BURST_M = w_sel.burst;
    assign PROT_M  = PROT_WIDTH'(w_sel.prot);
    assign LOCK_M  = w_sel.lock;

    assign req_out = w_pend | (HSELS & (HTRANSS != TRANS_IDLE));

    always_comb begin
        HREADYOUTS = 1'b1;
        if (w_pend) begin
            HREADYOUTS = 1'b0;
        end else if (data_sel) begin
            HREADYOUTS = hready_m;
        end
    end

    assign HRESPS = data_sel ? hresp_m : RESP_OKAY;

endmodule

// File: tb/tb_ahb_mtx_in_stage.sv
// Self-checking bench for ahb_mtx_in_stage: directed vector table, async reset check,
// then randomized traffic against a queue-based reference model.
module tb_ahb_mtx_in_stage;

`ifdef AHB_MTX_IN_ERR_CANCEL_EN
    localparam bit CancelEn = 1'b1;
`else
    localparam bit CancelEn = 1'b0;
`endif

    logic        HCLK, HRESETn, HSELS, HWRITES, HMASTLOCKS, HREADYS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic [2:0]  HSIZES, HBURSTS;
    logic [3:0]  HPROTS;
    logic        HREADYOUTS, HRESPS;
    logic        grant_in, hready_m, hresp_m, data_sel;
    logic        req_out, WRITE_M, LOCK_M, pend;
    logic [31:0] ADDR_M;
    logic [1:0]  TRANS_M;
    logic [2:0]  SIZE_M, BURST_M;
    logic [3:0]  PROT_M;

    ahb_mtx_in_stage #(.ADDR_WIDTH(32), .PROT_WIDTH(4)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HSELS      (HSELS),
        .HADDRS     (HADDRS),
        .HTRANSS    (HTRANSS),
        .HWRITES    (HWRITES),
        .HSIZES     (HSIZES),
        .HBURSTS    (HBURSTS),
        .HPROTS     (HPROTS),
        .HMASTLOCKS (HMASTLOCKS),
        .HREADYS    (HREADYS),
        .HREADYOUTS (HREADYOUTS),
        .HRESPS     (HRESPS),
        .grant_in   (grant_in),
        .hready_m   (hready_m),
        .hresp_m    (hresp_m),
        .data_sel   (data_sel),
        .req_out    (req_out),
        .ADDR_M     (ADDR_M),
        .TRANS_M    (TRANS_M),
        .WRITE_M    (WRITE_M),
        .SIZE_M     (SIZE_M),
        .BURST_M    (BURST_M),
        .PROT_M     (PROT_M),
        .LOCK_M     (LOCK_M),
        .pend       (pend)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          sel, rdy;
        logic [1:0]  trans;
        bit          wr, lock;
        logic [31:0] addr;
        bit          grant, hrm, hresp, ds;
        bit          e_pend, e_req, e_hro, e_hrs;
        logic [31:0] e_addr;
        bit          e_lock;
    } row_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size, burst;
        logic [3:0]  prot;
        logic        lock;
    } xfer_t;

    row_t  vec[18];
    xfer_t hold_q[$];

    function automatic xfer_t live_xfer();
        xfer_t x;
        x.addr  = HADDRS;
        x.trans = HTRANSS;
        x.write = HWRITES;
        x.size  = HSIZES;
        x.burst = HBURSTS;
        x.prot  = HPROTS;
        x.lock  = HMASTLOCKS;
        return x;
    endfunction

    // Reference: at most one transfer waits; it leaves when accepted or (optionally) on ERROR.
    task automatic model_edge();
        bit nt;
        nt = HSELS && HREADYS && (HTRANSS != 2'b00);
        if (hold_q.size() == 0) begin
            if (nt && !(grant_in && hready_m)) hold_q.push_back(live_xfer());
        end else if ((grant_in && hready_m) ||
                     (CancelEn && data_sel && hresp_m && !hready_m)) begin
            hold_q.delete();
        end
    endtask

    task automatic model_check();
        xfer_t e;
        bit    p;
        p = (hold_q.size() != 0);
        e = p ? hold_q[0] : live_xfer();
        chk("pend", pend, p);
        chk("req_out", req_out, p || (HSELS && HTRANSS != 2'b00));
        chk("HREADYOUTS", HREADYOUTS, p ? 1'b0 : (data_sel ? hready_m : 1'b1));
        chk("HRESPS", HRESPS, data_sel ? hresp_m : 1'b0);
        chk("ADDR_M", ADDR_M, e.addr);
        chk("TRANS_M", TRANS_M, e.trans);
        chk("WRITE_M", WRITE_M, e.write);
        chk("SIZE_M", SIZE_M, e.size);
        chk("BURST_M", BURST_M, e.burst);
        chk("PROT_M", PROT_M, e.prot);
        chk("LOCK_M", LOCK_M, e.lock);
    endtask

    initial begin
        bit c, nc;
        c  = CancelEn;
        nc = !CancelEn;
        vec[0]  = '{0, 1, 2'b00, 0, 0, 32'h0,         0, 1, 0, 0, 0, 0, 1, 0, 32'h0,         0};
        vec[1]  = '{1, 1, 2'b10, 1, 0, 32'h2000_0000, 1, 1, 0, 0, 0, 1, 1, 0, 32'h2000_0000, 0};
        vec[2]  = '{1, 1, 2'b10, 0, 0, 32'h4000_0010, 0, 1, 0, 1, 0, 1, 1, 0, 32'h4000_0010, 0};
        vec[3]  = '{1, 0, 2'b10, 1, 0, 32'hDEAD_BEEF, 0, 1, 0, 1, 1, 1, 0, 0, 32'h4000_0010, 0};
        vec[4]  = '{1, 0, 2'b10, 1, 0, 32'hDEAD_BEEF, 0, 1, 0, 1, 1, 1, 0, 0, 32'h4000_0010, 0};
        vec[5]  = '{1, 0, 2'b10, 1, 0, 32'hDEAD_BEEF, 1, 1, 0, 1, 1, 1, 0, 0, 32'h4000_0010, 0};
        vec[6]  = '{1, 1, 2'b00, 1, 0, 32'hDEAD_BEEF, 0, 1, 0, 1, 0, 0, 1, 0, 32'hDEAD_BEEF, 0};
        vec[7]  = '{0, 0, 2'b00, 0, 0, 32'h0,         0, 0, 1, 1, 0, 0, 0, 1, 32'h0,         0};
        vec[8]  = '{0, 1, 2'b00, 0, 0, 32'h0,         0, 1, 1, 1, 0, 0, 1, 1, 32'h0,         0};
        vec[9]  = '{1, 1, 2'b10, 0, 1, 32'h1234_5678, 0, 1, 0, 0, 0, 1, 1, 0, 32'h1234_5678, 1};
        vec[10] = '{0, 0, 2'b00, 0, 0, 32'h0,         0, 1, 0, 0, 1, 1, 0, 0, 32'h1234_5678, 1};
        vec[11] = '{0, 0, 2'b00, 0, 0, 32'h0,         1, 1, 0, 0, 1, 1, 0, 0, 32'h1234_5678, 1};
        vec[12] = '{0, 1, 2'b00, 0, 0, 32'h0,         0, 1, 0, 0, 0, 0, 1, 0, 32'h0,         0};
        vec[13] = '{1, 1, 2'b10, 0, 0, 32'h300,       0, 1, 0, 0, 0, 1, 1, 0, 32'h300,       0};
        vec[14] = '{0, 0, 2'b00, 0, 0, 32'h300,       0, 0, 1, 1, 1, 1, 0, 1, 32'h300,       0};
        vec[15] = '{0, 0, 2'b00, 0, 0, 32'h300,       0, 1, 1, 1, nc, nc, c, 1, 32'h300,     0};
        vec[16] = '{0, 1, 2'b00, 0, 0, 32'h300,       1, 1, 0, 0, nc, nc, c, 0, 32'h300,     0};
        vec[17] = '{0, 1, 2'b00, 0, 0, 32'h0,         0, 1, 0, 0, 0, 0, 1, 0, 32'h0,         0};

        HRESETn = 1'b0; HSELS = 1'b0; HADDRS = '0; HTRANSS = 2'b00; HWRITES = 1'b0;
        HSIZES = 3'd0; HBURSTS = 3'd0; HPROTS = 4'd0; HMASTLOCKS = 1'b0; HREADYS = 1'b1;
        grant_in = 1'b0; hready_m = 1'b1; hresp_m = 1'b0; data_sel = 1'b0;
        #3;
        chk("rst_pend", pend, 1'b0);
        chk("rst_req_out", req_out, 1'b0);
        chk("rst_HREADYOUTS", HREADYOUTS, 1'b1);
        chk("rst_HRESPS", HRESPS, 1'b0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(posedge HCLK);
            #1;
            HSELS = vec[i].sel; HREADYS = vec[i].rdy; HTRANSS = vec[i].trans;
            HWRITES = vec[i].wr; HMASTLOCKS = vec[i].lock; HADDRS = vec[i].addr;
            grant_in = vec[i].grant; hready_m = vec[i].hrm;
            hresp_m = vec[i].hresp; data_sel = vec[i].ds;
            @(negedge HCLK);
            chk($sformatf("v%0d_pend", i), pend, vec[i].e_pend);
            chk($sformatf("v%0d_req_out", i), req_out, vec[i].e_req);
            chk($sformatf("v%0d_HREADYOUTS", i), HREADYOUTS, vec[i].e_hro);
            chk($sformatf("v%0d_HRESPS", i), HRESPS, vec[i].e_hrs);
            chk($sformatf("v%0d_ADDR_M", i), ADDR_M, vec[i].e_addr);
            chk($sformatf("v%0d_LOCK_M", i), LOCK_M, vec[i].e_lock);
        end

        // Asynchronous reset while a transfer is held.
        @(posedge HCLK);
        #1;
        HSELS = 1'b1; HREADYS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h5555_0000;
        grant_in = 1'b0; hready_m = 1'b1; data_sel = 1'b0; hresp_m = 1'b0;
        @(posedge HCLK);
        #1;
        HSELS = 1'b0; HTRANSS = 2'b00; HREADYS = 1'b0;
        #1;
        chk("arst_pre_pend", pend, 1'b1);
        HRESETn = 1'b0;
        #1;
        chk("arst_pend", pend, 1'b0);
        chk("arst_req_out", req_out, 1'b0);
        chk("arst_HREADYOUTS", HREADYOUTS, 1'b1);
        #1;
        HRESETn = 1'b1;
        hold_q.delete();

        for (int n = 0; n < 400; n++) begin
            @(posedge HCLK);
            model_edge();
            #1;
            HSELS      = ($urandom_range(0, 3) != 0);
            HREADYS    = ($urandom_range(0, 3) != 0);
            HTRANSS    = 2'($urandom_range(0, 3));
            HADDRS     = $urandom;
            HWRITES    = 1'($urandom_range(0, 1));
            HSIZES     = 3'($urandom_range(0, 7));
            HBURSTS    = 3'($urandom_range(0, 7));
            HPROTS     = 4'($urandom_range(0, 15));
            HMASTLOCKS = 1'($urandom_range(0, 1));
            grant_in   = 1'($urandom_range(0, 1));
            hready_m   = ($urandom_range(0, 2) != 0);
            hresp_m    = ($urandom_range(0, 3) == 0);
            data_sel   = 1'($urandom_range(0, 1));
            @(negedge HCLK);
            model_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
